// File: rtl/log_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : log_mult_seq
// Purpose  : Multi-cycle Mitchell log-multiply sequencer with valid/ready I/O.
// Revision : 1.0 - initial release
// ============================================================================
module log_mult_seq #(
    parameter int DWIDTH    = 16,
    parameter int M_WIDTH   = 6,
    parameter int CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DWIDTH-1:0]     in_a,
    input  logic [DWIDTH-1:0]     in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DWIDTH-1:0]   out_product,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  op_count
);

    localparam int c_kw = $clog2(DWIDTH);
    localparam int c_pw = 2 * DWIDTH;
    localparam int c_xw = DWIDTH + M_WIDTH;
    localparam logic [c_kw:0] c_m = (c_kw + 1)'(M_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOD   = 3'd1,
        S_ADD   = 3'd2,
        S_ANTI  = 3'd3,
        S_SHIFT = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [DWIDTH-1:0]      r_a;
    logic [DWIDTH-1:0]      r_b;
    logic                   r_zero;
    logic [c_kw-1:0]        r_ka;
    logic [c_kw-1:0]        r_kb;
    logic [M_WIDTH-1:0]     r_xa;
    logic [M_WIDTH-1:0]     r_xb;
    logic [c_kw:0]          r_sum_k;
    logic [M_WIDTH:0]       r_sum_x;
    logic [c_kw:0]          r_final_k;
    logic [M_WIDTH:0]       r_mant;
    logic [c_pw-1:0]        r_product;
    logic [CNT_WIDTH-1:0]   r_count;

    logic [c_kw-1:0]        w_ka;
    logic [c_kw-1:0]        w_kb;
    logic [M_WIDTH-1:0]     w_xa;
    logic [M_WIDTH-1:0]     w_xb;
    logic [c_pw-1:0]        w_mant_ext;
    logic [c_pw-1:0]        w_prod;

    // Index of the highest set bit; zero for a zero operand (masked by r_zero).
    function automatic logic [c_kw-1:0] f_lead_one(input logic [DWIDTH-1:0] v);
        logic [c_kw-1:0] k;
        k = '0;
        for (int i = 0; i < DWIDTH; i++) begin
            if (v[i]) begin
                k = c_kw'(i);
            end
        end
        return k;
    endfunction

    // Appending M_WIDTH zeros and shifting right by k leaves the M_WIDTH bits
    // below the leading one, left-aligned and zero-filled when k < M_WIDTH.
    function automatic logic [M_WIDTH-1:0] f_frac(input logic [DWIDTH-1:0] v,
                                                  input logic [c_kw-1:0]   k);
        logic [c_xw-1:0] ext;
        ext = {v, {M_WIDTH{1'b0}}} >> k;
        return ext[M_WIDTH-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_nxt = S_LOD;
            S_LOD:   w_state_nxt = S_ADD;
            S_ADD:   w_state_nxt = S_ANTI;
            S_ANTI:  w_state_nxt = S_SHIFT;
            S_SHIFT: w_state_nxt = S_OUT;
            S_OUT:   if (out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ka = f_lead_one(r_a);
        w_kb = f_lead_one(r_b);
        w_xa = f_frac(r_a, w_ka);
        w_xb = f_frac(r_b, w_kb);
    end

    // Reconstruct 2^final_k * (1.mant) by aligning the mantissa point.
    always_comb begin
        w_mant_ext = {{(c_pw - M_WIDTH - 1){1'b0}}, r_mant};
        w_prod     = '0;
        if (r_final_k >= c_m) begin
            w_prod = w_mant_ext << (r_final_k - c_m);
        end else begin
            w_prod = w_mant_ext >> (c_m - r_final_k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_zero    <= 1'b0;
            r_ka      <= '0;
            r_kb      <= '0;
            r_xa      <= '0;
            r_xb      <= '0;
            r_sum_k   <= '0;
            r_sum_x   <= '0;
            r_final_k <= '0;
            r_mant    <= '0;
            r_product <= '0;
            r_count   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a    <= in_a;
                        r_b    <= in_b;
                        r_zero <= (in_a == '0) || (in_b == '0);
                    end
                end
                S_LOD: begin
                    r_ka <= w_ka;
                    r_kb <= w_kb;
                    r_xa <= w_xa;
                    r_xb <= w_xb;
                end
                S_ADD: begin
                    r_sum_k <= {1'b0, r_ka} + {1'b0, r_kb};
                    r_sum_x <= {1'b0, r_xa} + {1'b0, r_xb};
                end
                S_ANTI: begin
                    r_final_k <= r_sum_k + {{c_kw{1'b0}}, r_sum_x[M_WIDTH]};
                    r_mant    <= {1'b1, r_sum_x[M_WIDTH-1:0]};
                end
                S_SHIFT: begin
                    r_product <= r_zero ? '0 : w_prod;
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_count <= r_count + CNT_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign out_valid   = (r_state == S_OUT);
    assign out_product = r_product;
    assign op_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_log_mult_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_log_mult_seq
// Purpose  : Scoreboard bench for log_mult_seq (latency, products, stalls, reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_log_mult_seq;

    localparam int DW = 16;
    localparam int MW = 6;
    localparam int CW = 2;
    localparam int PW = 2 * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_product;
    logic          busy;
    logic [CW-1:0] op_count;

    int            n_vec = 0;
    int            n_err = 0;
    int            exp_count = 0;
    logic [PW-1:0] sb_q[$];

    always #5 clk = ~clk;

    log_mult_seq #(
        .DWIDTH    (DW),
        .M_WIDTH   (MW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_product (out_product),
        .busy        (busy),
        .op_count    (op_count)
    );

    // Mitchell approximation in integer arithmetic:
    // frac = floor((v - 2^k) * 2^MW / 2^k), product = floor((2^MW + frac) * 2^k / 2^MW).
    function automatic logic [PW-1:0] model(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint ka = 0;
        longint kb = 0;
        longint fa, fb, s, k, mant;
        if (a == 0 || b == 0) return '0;
        for (int i = 0; i < DW; i++) begin
            if (a[i]) ka = i;
            if (b[i]) kb = i;
        end
        fa = ((longint'(a) - (longint'(1) << ka)) << MW) >> ka;
        fb = ((longint'(b) - (longint'(1) << kb)) << MW) >> kb;
        s  = fa + fb;
        k  = ka + kb;
        if (s >= (longint'(1) << MW)) begin
            k = k + 1;
            s = s - (longint'(1) << MW);
        end
        mant = (longint'(1) << MW) + s;
        return PW'((mant << k) >> MW);
    endfunction

    // Called #1 after a rising edge; returns after the accepting edge (+1 time unit).
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, output bit ok);
        ok       = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Counts cycles after the accept until out_valid is seen; -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_vec++; if (out_product !== '0) begin n_err++; $display("FAIL reset_product: got %0h want 0", out_product); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (op_count !== '0) begin n_err++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
    endtask

    task automatic test_first_op();
        bit ok;
        int lat;
        logic [PW-1:0] exp;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        sb_q.push_back(32'd8);
        send(16'd3, 16'd3, ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL first_accept: got 0 want 1"); end
        wait_valid(lat);
        n_vec++; if (lat !== 5) begin n_err++; $display("FAIL first_latency: got %0d want 5", lat); end
        exp = sb_q.pop_front();
        n_vec++; if (out_product !== exp) begin n_err++; $display("FAIL first_product: got %0h want %0h", out_product, exp); end
        @(posedge clk);
        exp_count++;
        #1;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL first_busy_after: got %b want 0", busy); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL first_valid_after: got %b want 0", out_valid); end
        n_vec++; if (op_count !== CW'(exp_count)) begin n_err++; $display("FAIL first_op_count: got %0d want %0d", op_count, CW'(exp_count)); end
    endtask

    task automatic test_products();
        logic [DW-1:0] ta[9];
        logic [DW-1:0] tb[9];
        logic [PW-1:0] te[9];
        logic [PW-1:0] exp;
        bit ok;
        int lat;
        ta[0] = 16'd100;   tb[0] = 16'd10;    te[0] = 32'd928;
        ta[1] = 16'd1;     tb[1] = 16'd1;     te[1] = 32'd1;
        ta[2] = 16'hFFFF;  tb[2] = 16'hFFFF;  te[2] = 32'hFC000000;
        ta[3] = 16'd0;     tb[3] = 16'd500;   te[3] = 32'd0;
        ta[4] = 16'd500;   tb[4] = 16'd0;     te[4] = 32'd0;
        for (int i = 5; i < 9; i++) begin
            ta[i] = DW'($urandom_range(1, 65535));
            tb[i] = DW'($urandom_range(1, 65535));
            te[i] = model(ta[i], tb[i]);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            sb_q.push_back(te[i]);
            send(ta[i], tb[i], ok);
            wait_valid(lat);
            n_vec++; if (lat !== 5) begin n_err++; $display("FAIL prod_latency[%0d]: got %0d want 5", i, lat); end
            exp = sb_q.pop_front();
            n_vec++; if (out_product !== exp) begin n_err++; $display("FAIL prod[%0d] %0h*%0h: got %0h want %0h", i, ta[i], tb[i], out_product, exp); end
            @(posedge clk);
            exp_count++;
            #1;
        end
        n_vec++; if (op_count !== CW'(exp_count)) begin n_err++; $display("FAIL prod_op_count: got %0d want %0d", op_count, CW'(exp_count)); end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] held;
        logic [PW-1:0] exp;
        logic [CW-1:0] cnt_before;
        bit ok;
        int lat;
        int bad;
        out_ready = 1'b0;
        sb_q.push_back(model(16'd1234, 16'd777));
        send(16'd1234, 16'd777, ok);
        wait_valid(lat);
        held       = out_product;
        cnt_before = op_count;
        exp = sb_q.pop_front();
        n_vec++; if (out_product !== exp) begin n_err++; $display("FAIL bp_product: got %0h want %0h", out_product, exp); end
        sb_q.push_back(model(16'd4321, 16'd99));
        in_valid = 1'b1;
        in_a     = 16'd4321;
        in_b     = 16'd99;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_product !== held || in_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL bp_stall_stable: got %0d bad cycles want 0", bad); end
        n_vec++; if (op_count !== cnt_before) begin n_err++; $display("FAIL bp_count_stalled: got %0d want %0d", op_count, cnt_before); end
        out_ready = 1'b1;
        @(posedge clk);
        exp_count++;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_idle_ready: got %b want 1", in_ready); end
        n_vec++; if (op_count !== CW'(exp_count)) begin n_err++; $display("FAIL bp_count_once: got %0d want %0d", op_count, CW'(exp_count)); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_next_accept: got busy %b want 1", busy); end
        wait_valid(lat);
        n_vec++; if (lat !== 5) begin n_err++; $display("FAIL bp_next_latency: got %0d want 5", lat); end
        exp = sb_q.pop_front();
        n_vec++; if (out_product !== exp) begin n_err++; $display("FAIL bp_next_product: got %0h want %0h", out_product, exp); end
        @(posedge clk);
        exp_count++;
        #1;
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        int seen;
        out_ready = 1'b1;
        sb_q.push_back(model(16'd300, 16'd45));
        send(16'd300, 16'd45, ok);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(sb_q.pop_back());
        exp_count = 0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_out_valid: got %b want 0", out_valid); end
        n_vec++; if (op_count !== '0) begin n_err++; $display("FAIL rstmid_op_count: got %0d want 0", op_count); end
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        n_vec++; if (seen != 0) begin n_err++; $display("FAIL rstmid_no_result: got %0d valid cycles want 0", seen); end
    endtask

    task automatic test_count_wrap();
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [PW-1:0] exp;
        bit ok;
        int lat;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            a = DW'($urandom);
            b = DW'($urandom);
            sb_q.push_back(model(a, b));
            send(a, b, ok);
            wait_valid(lat);
            exp = sb_q.pop_front();
            n_vec++; if (out_product !== exp) begin n_err++; $display("FAIL wrap_prod[%0d] %0h*%0h: got %0h want %0h", i, a, b, out_product, exp); end
            @(posedge clk);
            exp_count++;
            #1;
        end
        n_vec++; if (op_count !== 2'd1) begin n_err++; $display("FAIL wrap_op_count: got %0d want 1", op_count); end
    endtask

    initial begin
        test_reset();
        test_first_op();
        test_products();
        test_backpressure();
        test_reset_mid_op();
        test_count_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
